// File: rtl/adc_frame_packer.sv
`default_nettype none
// ============================================================================
// Module : adc_frame_packer
// Turns synchronized ADC capture events into 11-word checksummed stream frames.
// Rev    : 1.0  initial release
// ============================================================================
module adc_frame_packer #(
  parameter logic [15:0] HEADER      = 16'hA5A5,
  parameter int          SYNC_STAGES = 2
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         pkt_enable,
  input  logic         adc_read_done,
  input  logic [127:0] adc_ch_data,
  output logic [15:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic [15:0]  frame_cnt,
  output logic [15:0]  drop_cnt,
  output logic         busy
);

  localparam logic [3:0] c_last_idx = 4'd10;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_edge;
  logic                   r_armed;
  logic [3:0]             r_idx;
  logic [127:0]           r_act_data;
  logic [127:0]           r_pend_data;
  logic [15:0]            r_act_seq;
  logic [15:0]            r_pend_seq;
  logic [15:0]            r_seq;
  logic                   r_pend_full;

  logic                   w_sync_out;
  logic                   w_cap_evt;
  logic                   w_xfer;
  logic                   w_last_xfer;
  logic [3:0]             w_next_idx;
  logic [15:0]            w_csum;
  logic [15:0]            w_next_word;

  assign w_sync_out  = r_sync[SYNC_STAGES-1];
  assign w_cap_evt   = w_sync_out & ~r_edge & r_armed & pkt_enable;
  assign w_xfer      = m_valid & m_ready;
  assign w_last_xfer = w_xfer & (r_idx == c_last_idx);
  assign w_next_idx  = r_idx + 4'd1;
  assign busy        = (r_state == ST_SEND) | r_pend_full;

  always_comb begin
    w_csum = r_act_seq;
    for (int i = 0; i < 8; i++) begin
      w_csum = w_csum + r_act_data[16*i +: 16];
    end
  end

  always_comb begin
    w_next_word = w_csum;
    case (w_next_idx)
      4'd1:    w_next_word = r_act_seq;
      4'd2:    w_next_word = r_act_data[15:0];
      4'd3:    w_next_word = r_act_data[31:16];
      4'd4:    w_next_word = r_act_data[47:32];
      4'd5:    w_next_word = r_act_data[63:48];
      4'd6:    w_next_word = r_act_data[79:64];
      4'd7:    w_next_word = r_act_data[95:80];
      4'd8:    w_next_word = r_act_data[111:96];
      4'd9:    w_next_word = r_act_data[127:112];
      default: w_next_word = w_csum;
    endcase
  end

  // r_fill marks when the sync chain holds real samples, so a flag already
  // high at reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_edge  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], adc_read_done};
      r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_edge  <= w_sync_out;
      r_armed <= r_armed | (r_fill[SYNC_STAGES-1] & ~w_sync_out);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_act_data  <= '0;
      r_act_seq   <= '0;
      r_pend_data <= '0;
      r_pend_seq  <= '0;
      r_pend_full <= 1'b0;
      r_seq       <= '0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cap_evt) begin
            r_act_data <= adc_ch_data;
            r_act_seq  <= r_seq;
            r_seq      <= r_seq + 16'd1;
            r_idx      <= '0;
            m_data     <= HEADER;
            m_valid    <= 1'b1;
            m_last     <= 1'b0;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // A full slot drops the event even if it drains this very cycle.
          if (w_cap_evt) begin
            if (r_pend_full) begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end else begin
              r_seq <= r_seq + 16'd1;
              if (!w_last_xfer) begin
                r_pend_full <= 1'b1;
                r_pend_data <= adc_ch_data;
                r_pend_seq  <= r_seq;
              end
            end
          end
          if (w_last_xfer) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (r_pend_full || w_cap_evt) begin
              r_act_data  <= r_pend_full ? r_pend_data : adc_ch_data;
              r_act_seq   <= r_pend_full ? r_pend_seq : r_seq;
              r_pend_full <= 1'b0;
              r_idx       <= '0;
              m_data      <= HEADER;
              m_last      <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              m_data  <= '0;
            end
          end else if (w_xfer) begin
            r_idx  <= w_next_idx;
            m_data <= w_next_word;
            m_last <= (w_next_idx == c_last_idx);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/adc_frame_packer.md
ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 SHALL have parameter HEADER, default 16'hA5A5, first word of every frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for adc_read_done (legal 2..4).
REQ-003 SHALL have port sys_clk  in  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port pkt_enable  in  1  frame generation enable.
REQ-006 SHALL have port adc_read_done  in  1  capture-complete flag from ADC capture stage (foreign clock).
REQ-007 SHALL have port adc_ch_data  in  128  channel data, ch1 in [15:0] through ch8 in [127:112]; stable while adc_read_done high.
REQ-008 SHALL have port m_data  out  16  stream data word.
REQ-009 SHALL have port m_valid  out  1  stream word valid.
REQ-010 SHALL have port m_ready  in  1  downstream accept.
REQ-011 SHALL have port m_last  out  1  marks final word (checksum) of a frame.
REQ-012 SHALL have port frame_cnt  out  16  frames fully transferred, wraps.
REQ-013 SHALL have port drop_cnt  out  16  captures discarded, saturates at 16'hFFFF.
REQ-014 SHALL have port busy  out  1  high when state is SEND or the pending slot is full.

Function
REQ-015 SHALL pass adc_read_done through a SYNC_STAGES flop synchronizer, then a one-flop rising-edge detector; one "capture event" per detected rising edge.
REQ-016 SHALL sample adc_ch_data into a snapshot in the same cycle the capture event is detected.
REQ-017 SHALL ignore capture events while pkt_enable is low: no snapshot, no drop count.
REQ-018 SHALL implement states IDLE and SEND, plus one pending snapshot slot.
REQ-019 In IDLE, a capture event SHALL load the active snapshot, assign seq, and enter SEND; m_valid SHALL be high on the next cycle with word index 0.
REQ-020 Frame SHALL be 11 words: idx0 HEADER, idx1 seq, idx2..9 ch1..ch8, idx10 checksum.
REQ-021 Checksum SHALL be the 16-bit modulo-2^16 sum of words idx1..idx9; HEADER is excluded.
REQ-022 seq SHALL be a 16-bit counter that increments by 1 per accepted capture, starts at 0 after reset, and wraps FFFF->0000.
REQ-023 A word SHALL transfer only on a cycle where m_valid and m_ready are both high; m_data and m_last SHALL hold stable while m_valid is high and m_ready is low.
REQ-024 m_valid SHALL never deassert mid-frame once asserted; a frame is never truncated.
REQ-025 m_last SHALL be high only at idx10.
REQ-026 A capture event during SEND with the pending slot empty SHALL load the pending slot (data and seq).
REQ-027 A capture event while the pending slot is full SHALL be discarded and SHALL increment drop_cnt; this includes a pending slot being emptied in the same cycle.
REQ-028 On the idx10 transfer, frame_cnt SHALL increment.
  - If pending is full: move pending to active, stay in SEND, and emit idx0 on the next cycle (no idle gap).
  - Else: go to IDLE.
REQ-029 A capture event in the same cycle as the idx10 transfer, with pending empty, SHALL become the next active frame and follow the REQ-028 pending path.
REQ-030 pkt_enable deassertion SHALL NOT abort the current frame or a full pending slot; both complete normally.
REQ-031 Throughput: with m_ready held high, back-to-back frames SHALL occupy 11 consecutive cycles each.

Reset
REQ-032 Reset SHALL set state IDLE, pending slot empty, seq=0, frame_cnt=0, drop_cnt=0, m_valid=0, m_last=0, m_data=0, busy=0, and clear the synchronizer and edge flops.
REQ-033 Reset asserted mid-frame SHALL drop the partial frame immediately, with m_valid low in the same cycle (asynchronous).
REQ-034 After reset release, adc_read_done already high SHALL NOT produce a capture event until it falls and rises again.

Verification
REQ-035 Single frame, m_ready=1, ch1..ch8=0x0001..0x0008 -> A5A5, 0000, 0001..0008, checksum 0x0024, m_last on word 11; frame_cnt=1.
REQ-036 m_ready toggled 1-of-3 cycles during a frame -> identical 11 words, m_data stable during stalls, m_valid continuous.
REQ-037 Three capture events within one frame time, m_ready=0 -> first frame sent, second pending, third dropped; drop_cnt=1, seq values 0 and 1 emitted back-to-back.
REQ-038 Seq wrap: preload by running 65536 frames (or force) -> seq FFFF then 0000; checksum of all-FFFF channels with seq FFFF = 0xFFF7.
REQ-039 pkt_enable=0 with capture pulses -> no m_valid, drop_cnt unchanged; pkt_enable deasserted mid-frame -> frame completes.
REQ-040 rst_n asserted at idx5 -> m_valid=0 immediately, all counters 0; next capture event emits seq 0000.
